mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit sitting directly behind the EX/MEM pipeline register.
- Consumes the registered MEM-stage controls (MemWrite_M, ResultSrc_M, ALUResult_M, WriteData_M, Funct3_M) and runs a req/ack transaction on the data-memory port.
- Handles byte lanes and load extension, and raises Stall_M so the hazard unit freezes the front of the pipeline for multi-cycle accesses.

---
 rtl/mem_stage_lsu.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit with req/ack data-memory port
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite_M,
    input  logic [1:0]  ResultSrc_M,
    input  logic [2:0]  Funct3_M,
    input  logic [31:0] ALUResult_M,
    input  logic [31:0] WriteData_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] ReadData_M,
    output logic        Stall_M,
    output logic        MisalignErr_M,
    output logic        BusErr_M
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Decode of the instruction currently held in the EX/MEM register
    logic is_store, is_load, is_access;
    logic size_legal, aligned;
    logic access_ok, access_bad;
    logic start;

    // Store lane formatting computed from the live inputs, captured at start
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;

    // Request registers: hold the bus signals stable for the whole transaction
    logic [31:0] req_addr_q;
    logic        req_we_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_be_q;
    logic [2:0]  req_funct3_q;
    logic [1:0]  req_lo_q;

    // Cycles spent in ACCESS without an acknowledge
    logic [7:0]  wait_cnt_q;
    logic [8:0]  wait_inc;
    logic        timeout_hit;

    // Load extraction
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    logic [31:0] read_data_q;
    logic        bus_err_q;

    // Classify the presented access as legal/aligned or faulty
    always_comb begin
        is_store  = MemWrite_M;
        is_load   = (ResultSrc_M == 2'b01) && !MemWrite_M;
        is_access = is_store || is_load;

        size_legal = 1'b0;
        case (Funct3_M)
            3'b000, 3'b001, 3'b010: size_legal = 1'b1;
            3'b100, 3'b101:         size_legal = is_load;
            default:                size_legal = 1'b0;
        endcase

        aligned = 1'b1;
        case (Funct3_M[1:0])
            2'b01:   aligned = !ALUResult_M[0];
            2'b10:   aligned = (ALUResult_M[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        access_ok  = is_access && size_legal && aligned;
        access_bad = is_access && !(size_legal && aligned);
    end

    assign start = (state_q == S_IDLE) && access_ok;

    // Replicate store data across lanes and pick the byte enables
    always_comb begin
        lane_wdata = '0;
        lane_be    = 4'b1111;
        if (is_store) begin
            case (Funct3_M[1:0])
                2'b00: begin
                    lane_wdata = {4{WriteData_M[7:0]}};
                    lane_be    = 4'b0001 << ALUResult_M[1:0];
                end
                2'b01: begin
                    lane_wdata = {2{WriteData_M[15:0]}};
                    lane_be    = ALUResult_M[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    lane_wdata = WriteData_M;
                    lane_be    = 4'b1111;
                end
            endcase
        end
    end

    // Timeout fires on the ACCESS cycle that would bring the wait count to the limit
    always_comb begin
        wait_inc    = {1'b0, wait_cnt_q} + 9'd1;
        timeout_hit = (wait_inc == 9'(TIMEOUT_CYCLES));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE ignores the inputs so a completed instruction never re-triggers
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (access_ok) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (dmem_ack || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture the request at the detect edge; held until the next access starts
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q   <= '0;
            req_we_q     <= 1'b0;
            req_wdata_q  <= '0;
            req_be_q     <= '0;
            req_funct3_q <= '0;
            req_lo_q     <= '0;
        end else if (start) begin
            req_addr_q   <= {ALUResult_M[31:2], 2'b00};
            req_we_q     <= is_store;
            req_wdata_q  <= lane_wdata;
            req_be_q     <= lane_be;
            req_funct3_q <= Funct3_M;
            req_lo_q     <= ALUResult_M[1:0];
        end
    end

    // Count unacknowledged ACCESS cycles; cleared outside ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if ((state_q == S_ACCESS) && !dmem_ack && !timeout_hit) begin
            wait_cnt_q <= wait_inc[7:0];
        end else begin
            wait_cnt_q <= '0;
        end
    end

    // Select the addressed byte/half from the returned word and extend it
    always_comb begin
        rdata_shifted = dmem_rdata >> {req_lo_q, 3'b000};
        case (req_funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_ext = {24'd0, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_ext = {16'd0, rdata_shifted[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Load result: updated on ack, zeroed on timeout, otherwise held
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
        end else if ((state_q == S_ACCESS) && !req_we_q) begin
            if (dmem_ack) begin
                read_data_q <= load_ext;
            end else if (timeout_hit) begin
                read_data_q <= '0;
            end
        end
    end

    // Bus error is raised for the DONE cycle that follows a timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if ((state_q == S_ACCESS) && !dmem_ack && timeout_hit) begin
            bus_err_q <= 1'b1;
        end else if (state_q == S_DONE) begin
            bus_err_q <= 1'b0;
        end
    end

    assign dmem_req      = (state_q == S_ACCESS);
    assign dmem_we       = (state_q == S_ACCESS) && req_we_q;
    assign dmem_addr     = req_addr_q;
    assign dmem_wdata    = req_wdata_q;
    assign dmem_be       = req_be_q;
    assign ReadData_M    = read_data_q;
    assign BusErr_M      = bus_err_q;
    assign Stall_M       = start || (state_q == S_ACCESS);
    assign MisalignErr_M = (state_q == S_IDLE) && access_bad;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite_M;
    logic [1:0]  ResultSrc_M;
    logic [2:0]  Funct3_M;
    logic [31:0] ALUResult_M;
    logic [31:0] WriteData_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic [31:0] ReadData_M;
    logic        Stall_M;
    logic        MisalignErr_M;
    logic        BusErr_M;

    mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M), .Funct3_M(Funct3_M),
        .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .ReadData_M(ReadData_M), .Stall_M(Stall_M),
        .MisalignErr_M(MisalignErr_M), .BusErr_M(BusErr_M)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          ack_at;     // ACCESS cycle that acks; 0 or > T = never
        logic        pre;
        logic [31:0] pre_word;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
        int          exp_stall;
        logic        exp_bus;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [0:255];
    logic [31:0] model_rd;
    vec_t        tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        MemWrite_M  = 1'b0;
        ResultSrc_M = 2'b00;
        Funct3_M    = 3'b000;
        ALUResult_M = 32'h0;
        WriteData_M = 32'h0;
    endtask

    // Reference model: derive expectations from the access rules with plain arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        bit          st, ld, acc, legal, tmo;
        int          nb, sh;
        logic [31:0] val, mask;
        r   = v;
        st  = v.mw;
        ld  = (v.rs == 2'b01) && !v.mw;
        acc = st || ld;
        nb  = 1 << v.f3[1:0];
        sh  = int'(v.addr % 4);
        legal = st ? (v.f3 <= 3'd2) : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        r.exp_err   = acc && !(legal && ((v.addr % nb) == 0));
        tmo         = (v.ack_at == 0) || (v.ack_at > T);
        r.exp_bus   = tmo;
        r.exp_stall = 1 + (tmo ? T : v.ack_at);
        r.exp_be    = 4'hF;
        r.exp_wdata = 32'h0;
        r.exp_rd    = 32'h0;
        if (st && !r.exp_err) begin
            r.exp_be = 4'(((1 << nb) - 1) << sh);
            for (int i = 0; i < 4; i++) r.exp_wdata[8*i +: 8] = v.wd[8*(i % nb) +: 8];
        end
        if (ld && !r.exp_err && !tmo) begin
            val  = mem[v.addr[9:2]] >> (8 * sh);
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
            val  = val & mask;
            if (!v.f3[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
            r.exp_rd = val;
        end
        return r;
    endfunction

    // Present one instruction from the IDLE cycle through DONE; returns just after the next edge
    task automatic run_vec(input vec_t v, input string tag);
        bit acc, ld, done;
        int k, nstall;
        acc = v.mw || (v.rs == 2'b01);
        ld  = (v.rs == 2'b01) && !v.mw;
        if (v.pre) mem[v.addr[9:2]] = v.pre_word;
        MemWrite_M  = v.mw;
        ResultSrc_M = v.rs;
        Funct3_M    = v.f3;
        ALUResult_M = v.addr;
        WriteData_M = v.wd;
        dmem_ack    = 1'b0;
        @(negedge clk);
        chk({tag, " misalign"}, 32'(MisalignErr_M), 32'(v.exp_err));
        chk({tag, " detect_req"}, 32'(dmem_req), 32'h0);
        chk({tag, " detect_bus"}, 32'(BusErr_M), 32'h0);
        chk({tag, " detect_stall"}, 32'(Stall_M), 32'(acc && !v.exp_err));
        if (!acc || v.exp_err) begin
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            chk({tag, " after_misalign"}, 32'(MisalignErr_M), 32'h0);
            chk({tag, " after_req"}, 32'(dmem_req), 32'h0);
            chk({tag, " rd_hold"}, ReadData_M, model_rd);
            @(posedge clk); #1;
            return;
        end
        nstall = 1;
        k = 0;
        done = 0;
        while (!done && k < T + 2) begin
            @(posedge clk); #1;
            k++;
            dmem_ack   = (k == v.ack_at);
            dmem_rdata = dmem_ack ? mem[v.addr[9:2]] : $urandom;
            @(negedge clk);
            chk({tag, " req"}, 32'(dmem_req), 32'h1);
            chk({tag, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
            chk({tag, " we"}, 32'(dmem_we), 32'(v.mw));
            chk({tag, " be"}, 32'(dmem_be), 32'(v.exp_be));
            if (v.mw) chk({tag, " wdata"}, dmem_wdata, v.exp_wdata);
            if (Stall_M) nstall++;
            if (dmem_ack) begin
                done = 1;
                if (v.mw)
                    for (int i = 0; i < 4; i++)
                        if (v.exp_be[i]) mem[v.addr[9:2]][8*i +: 8] = v.exp_wdata[8*i +: 8];
            end else if (k == T) begin
                done = 1;
            end
        end
        @(posedge clk); #1;
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        @(negedge clk);
        if (ld) model_rd = v.exp_rd;
        chk({tag, " done_stall"}, 32'(Stall_M), 32'h0);
        chk({tag, " done_req"}, 32'(dmem_req), 32'h0);
        chk({tag, " done_bus"}, 32'(BusErr_M), 32'(v.exp_bus));
        chk({tag, " read_data"}, ReadData_M, model_rd);
        chk({tag, " stall_cycles"}, 32'(nstall), 32'(v.exp_stall));
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        model_rd   = 32'h0;
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive_idle();

        //              mw    rs     f3      addr         wd            ack pre   pre_word      err   be     wdata         rd            stall bus
        tbl[0]  = '{1'b0, 2'b01, 3'b000, 32'h103, 32'h0,        1, 1'b1, 32'h80FF1234, 1'b0, 4'hF, 32'h0,        32'hFFFFFF80, 2, 1'b0};
        tbl[1]  = '{1'b0, 2'b01, 3'b100, 32'h101, 32'h0,        1, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'h00000012, 2, 1'b0};
        tbl[2]  = '{1'b0, 2'b01, 3'b001, 32'h102, 32'h0,        2, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'hFFFF80FF, 3, 1'b0};
        tbl[3]  = '{1'b1, 2'b00, 3'b001, 32'h202, 32'hAAAABEEF, 3, 1'b0, 32'h0,        1'b0, 4'hC, 32'hBEEFBEEF, 32'h0,        4, 1'b0};
        tbl[4]  = '{1'b0, 2'b01, 3'b010, 32'h005, 32'h0,        1, 1'b0, 32'h0,        1'b1, 4'hF, 32'h0,        32'h0,        0, 1'b0};
        tbl[5]  = '{1'b0, 2'b01, 3'b101, 32'h002, 32'h0,        0, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'h0,        5, 1'b1};
        tbl[6]  = '{1'b1, 2'b00, 3'b010, 32'h010, 32'h12345678, 1, 1'b0, 32'h0,        1'b0, 4'hF, 32'h12345678, 32'h0,        2, 1'b0};
        tbl[7]  = '{1'b0, 2'b01, 3'b010, 32'h010, 32'h0,        1, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'h12345678, 2, 1'b0};
        tbl[8]  = '{1'b1, 2'b00, 3'b000, 32'h203, 32'h000000A5, 2, 1'b0, 32'h0,        1'b0, 4'h8, 32'hA5A5A5A5, 32'h0,        3, 1'b0};
        tbl[9]  = '{1'b0, 2'b01, 3'b000, 32'h203, 32'h0,        1, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'hFFFFFFA5, 2, 1'b0};
        tbl[10] = '{1'b1, 2'b00, 3'b011, 32'h000, 32'h0,        1, 1'b0, 32'h0,        1'b1, 4'hF, 32'h0,        32'h0,        0, 1'b0};
        tbl[11] = '{1'b0, 2'b01, 3'b110, 32'h000, 32'h0,        1, 1'b0, 32'h0,        1'b1, 4'hF, 32'h0,        32'h0,        0, 1'b0};
        tbl[12] = '{1'b1, 2'b00, 3'b001, 32'h201, 32'h0,        1, 1'b0, 32'h0,        1'b1, 4'hF, 32'h0,        32'h0,        0, 1'b0};
        tbl[13] = '{1'b1, 2'b01, 3'b010, 32'h020, 32'hCAFEF00D, 1, 1'b0, 32'h0,        1'b0, 4'hF, 32'hCAFEF00D, 32'h0,        2, 1'b0};
        tbl[14] = '{1'b0, 2'b10, 3'b010, 32'h004, 32'h0,        1, 1'b0, 32'h0,        1'b0, 4'hF, 32'h0,        32'h0,        0, 1'b0};
        tbl[15] = '{1'b0, 2'b01, 3'b101, 32'h000, 32'h0,        4, 1'b1, 32'h00009876, 1'b0, 4'hF, 32'h0,        32'h00009876, 5, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req", 32'(dmem_req), 32'h0);
        chk("reset we", 32'(dmem_we), 32'h0);
        chk("reset addr", dmem_addr, 32'h0);
        chk("reset wdata", dmem_wdata, 32'h0);
        chk("reset be", 32'(dmem_be), 32'h0);
        chk("reset rd", ReadData_M, 32'h0);
        chk("reset stall", 32'(Stall_M), 32'h0);
        chk("reset misalign", 32'(MisalignErr_M), 32'h0);
        chk("reset bus", 32'(BusErr_M), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 120; n++) begin
            v.mw   = ($urandom_range(0, 2) == 0);
            v.rs   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) v.f3 = 3'($urandom_range(0, 7));
            else begin
                case ($urandom_range(0, 4))
                    0: v.f3 = 3'b000;
                    1: v.f3 = 3'b001;
                    2: v.f3 = 3'b010;
                    3: v.f3 = 3'b100;
                    default: v.f3 = 3'b101;
                endcase
            end
            v.addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.wd       = $urandom;
            v.ack_at   = $urandom_range(0, T + 1);
            v.pre      = 1'b0;
            v.pre_word = 32'h0;
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of an access, then a late ack that must be ignored
        v = '{1'b0, 2'b01, 3'b010, 32'h040, 32'h0, 1, 1'b1, 32'h5A5A0001,
              1'b0, 4'hF, 32'h0, 32'h5A5A0001, 2, 1'b0};
        run_vec(v, "pre_reset");
        MemWrite_M  = 1'b0;
        ResultSrc_M = 2'b01;
        Funct3_M    = 3'b010;
        ALUResult_M = 32'h44;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst req_before", 32'(dmem_req), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("midrst req", 32'(dmem_req), 32'h0);
        chk("midrst stall", 32'(Stall_M), 32'h0);
        chk("midrst rd", ReadData_M, 32'h0);
        chk("midrst bus", 32'(BusErr_M), 32'h0);
        chk("midrst addr", dmem_addr, 32'h0);
        chk("midrst be", 32'(dmem_be), 32'h0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack req", 32'(dmem_req), 32'h0);
        chk("late_ack rd", ReadData_M, 32'h0);
        chk("late_ack bus", 32'(BusErr_M), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
